i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 200000, SHALL set the cycles allowed in WAIT_BUSY+WAIT_DONE before abort; counter width is $clog2(TIMEOUT_CYCLES+1).
REQ-002 clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  [1:0]  per-requester command request, held until req_ready.
REQ-005 req_rw  in  [1:0]  per-requester 1:read, 0:write.
REQ-006 req_addr  in  [1:0][6:0]  per-requester 7-bit slave address.
REQ-007 req_din  in  [1:0][7:0]  per-requester write byte.
REQ-008 req_ready  out  [1:0]  one-cycle accept pulse, one-hot or zero.
REQ-009 rsp_valid  out  [1:0]  one-cycle completion pulse to the owning requester, one-hot or zero.
REQ-010 rsp_data  out  8  read byte, valid with rsp_valid.
REQ-011 rsp_err  out  1  NACK or timeout, valid with rsp_valid.
REQ-012 rsp_timeout  out  1  abort by timeout, valid with rsp_valid.
REQ-013 m_rw, m_addr[6:0], m_din[7:0], m_dataValid  out  command to the I2C master.
REQ-014 m_dout[7:0], m_busy, m_ackErr, m_done  in  status from the I2C master.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-017 IDLE with any req_valid SHALL:
- pick the owner round-robin;
- latch that requester's rw/addr/din;
- move to ISSUE.
REQ-018 Round-robin: with both valid, grant the requester not granted last; with one valid, grant it; last-grant resets to 1, so requester 0 wins the first contention.
REQ-019 ISSUE (one cycle) SHALL pulse req_ready[owner], assert m_dataValid with latched m_rw/m_addr/m_din, then move to WAIT_BUSY.
REQ-020 WAIT_BUSY SHALL hold m_dataValid high until m_busy=1, then deassert it and move to WAIT_DONE.
REQ-021 WAIT_DONE SHALL OR m_ackErr into a sticky error flag each cycle and move to RESP when m_done=1, capturing m_dout.
REQ-022 RESP (one cycle) SHALL:
- pulse rsp_valid[owner];
- present rsp_data and rsp_err (sticky flag OR timeout) and rsp_timeout;
- return to IDLE.
REQ-023 Latency: req_valid seen in IDLE at cycle N gives req_ready and m_dataValid at N+1; m_done at cycle M gives rsp_valid at M+1.
REQ-024 No new request SHALL be accepted outside IDLE; requests arriving then wait.
REQ-025 A requester dropping req_valid before req_ready is legal and SHALL be ignored.
REQ-026 rsp_data SHALL hold its last value between responses; m_addr/m_din/m_rw SHALL hold latched values until the next grant.
REQ-027 m_done in the same cycle as m_busy rising SHALL be treated as busy-then-done: go directly to RESP.

Reset
REQ-028 rst SHALL return to IDLE next edge, including mid-transaction, and clear to 0: req_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout, m_dataValid, m_rw, m_addr, m_din, the sticky error flag and the timeout counter; last-grant resets to 1.

Configuration
REQ-029 With I2C_ARB_TIMEOUT_EN defined:
- the counter runs in WAIT_BUSY/WAIT_DONE;
- at TIMEOUT_CYCLES it SHALL force m_dataValid=0 and go to RESP with rsp_err=1, rsp_timeout=1, rsp_data unchanged.
REQ-030 Without I2C_ARB_TIMEOUT_EN, no counter SHALL exist, the wait is unbounded, and rsp_timeout is constant 0.

Structure
REQ-031 Package i2c_arb_pkg SHALL hold the state_t enum, REQ_N=2 and ADDR_W=7/DATA_W=8 constants.
REQ-032 Sub-module i2c_rr_arbiter SHALL implement the 2-way round-robin grant and last-grant pointer; i2c_arbiter instantiates it once.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Single write: req_valid=01, addr=0x50, din=0xA5, rw=0 -> req_ready=01 next cycle; m_addr=0x50, m_din=0xA5; master done -> rsp_valid=01, rsp_err=0.
- Contention: both valid from reset -> requester 0 served first, requester 1 second; a further double request -> requester 0 again.
- Read with NACK: requester 1 rw=1, addr=0x51; master pulses m_ackErr once, m_dout=0x3C at done -> rsp_valid=10, rsp_data=0x3C, rsp_err=1.
- Timeout (macro on, TIMEOUT_CYCLES=50, m_busy never rises) -> rsp_valid after 50 wait cycles, rsp_err=1, rsp_timeout=1, m_dataValid=0.
- Reset mid-WAIT_DONE: assert rst one cycle -> next cycle all outputs 0, state IDLE; a pending request is then granted to requester 0.
- Glitch request: req_valid[0] high one cycle while in WAIT_DONE, low at return to IDLE -> no grant and no req_ready.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared constants and FSM state type for the I2C command arbiter.
package i2c_arb_pkg;

  localparam int unsigned REQ_N  = 2;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StResp
  } state_t;

endpackage

// File: rtl/i2c_arbiter_if.sv
// i2c_arbiter_if: requester command/response bundle plus the I2C master command/status lines.
// The slave modport is the arbiter's view; the master modport drives requests and master status.
interface i2c_arbiter_if;
  import i2c_arb_pkg::*;

  logic [REQ_N-1:0]             req_valid;
  logic [REQ_N-1:0]             req_rw;
  logic [REQ_N-1:0][ADDR_W-1:0] req_addr;
  logic [REQ_N-1:0][DATA_W-1:0] req_din;
  logic [REQ_N-1:0]             req_ready;
  logic [REQ_N-1:0]             rsp_valid;
  logic [DATA_W-1:0]            rsp_data;
  logic                         rsp_err;
  logic                         rsp_timeout;

  logic                         m_rw;
  logic [ADDR_W-1:0]            m_addr;
  logic [DATA_W-1:0]            m_din;
  logic                         m_dataValid;
  logic [DATA_W-1:0]            m_dout;
  logic                         m_busy;
  logic                         m_ackErr;
  logic                         m_done;

  modport slave (
    input  req_valid, req_rw, req_addr, req_din, m_dout, m_busy, m_ackErr, m_done,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
           m_rw, m_addr, m_din, m_dataValid
  );

  modport master (
    output req_valid, req_rw, req_addr, req_din, m_dout, m_busy, m_ackErr, m_done,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
           m_rw, m_addr, m_din, m_dataValid
  );

endinterface

// File: rtl/i2c_rr_arbiter.sv
// i2c_rr_arbiter: two-way round-robin grant with a last-grant pointer.
// The pointer resets to 1 so requester 0 wins the first contention.
module i2c_rr_arbiter
  import i2c_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_N-1:0] req_i,
  input  logic             accept_i,
  output logic             gnt_idx_o
);

  logic last_q, last_d;

  // Grant the requester not served last when both ask, otherwise the only one asking.
  always_comb begin
    if (req_i == 2'b11) begin
      gnt_idx_o = ~last_q;
    end else begin
      gnt_idx_o = req_i[1];
    end
  end

  // Pointer only moves when the grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (accept_i) begin
      last_d = gnt_idx_o;
    end
  end

  // Last-grant pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one I2C master between two requesters, one command at a time.
// Define I2C_ARB_TIMEOUT_EN to bound the busy/done wait by TIMEOUT_CYCLES.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic         clk,
  input  logic         rst,
  i2c_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [REQ_N-1:0]  req_ready_q, req_ready_d;
  logic [REQ_N-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              m_rw_q, m_rw_d;
  logic              m_dv_q, m_dv_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_din_q, m_din_d;
  logic              err_q, err_d;
  logic              gnt_idx, accept, in_wait, complete, cpl_err, timeout;

  assign accept  = (state_q == StIdle) && (|bus.req_valid);
  assign in_wait = (state_q == StWaitBusy) || (state_q == StWaitDone);

  i2c_rr_arbiter u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_i    (bus.req_valid),
    .accept_i (accept),
    .gnt_idx_o(gnt_idx)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            rsp_timeout_q, rsp_timeout_d;

  assign cnt_inc = cnt_q + CntW'(1);
  assign timeout = in_wait && (cnt_inc == CntW'(TIMEOUT_CYCLES));
  assign bus.rsp_timeout = rsp_timeout_q;

  // Wait counter runs only while waiting on the master; timeout flag follows the response.
  always_comb begin
    cnt_d         = in_wait ? cnt_inc : '0;
    rsp_timeout_d = rsp_timeout_q;
    if (complete) begin
      rsp_timeout_d = 1'b0;
    end else if (timeout) begin
      rsp_timeout_d = 1'b1;
    end
  end

  // Timeout counter and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign bus.rsp_timeout    = 1'b0;
`endif

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.m_rw        = m_rw_q;
  assign bus.m_addr      = m_addr_q;
  assign bus.m_din       = m_din_q;
  assign bus.m_dataValid = m_dv_q;

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    m_rw_d      = m_rw_q;
    m_dv_d      = m_dv_q;
    m_addr_d    = m_addr_q;
    m_din_d     = m_din_q;
    err_d       = err_q;
    complete    = 1'b0;
    cpl_err     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d              = gnt_idx;
          m_rw_d               = bus.req_rw[gnt_idx];
          m_addr_d             = bus.req_addr[gnt_idx];
          m_din_d              = bus.req_din[gnt_idx];
          err_d                = 1'b0;
          req_ready_d[gnt_idx] = 1'b1;
          m_dv_d               = 1'b1;
          state_d              = StIssue;
        end
      end
      StIssue: begin
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.m_busy) begin
          m_dv_d = 1'b0;
          // Busy and done together: the command already finished.
          if (bus.m_done) begin
            complete = 1'b1;
            cpl_err  = err_q | bus.m_ackErr;
          end else begin
            state_d = StWaitDone;
          end
        end
      end
      StWaitDone: begin
        err_d = err_q | bus.m_ackErr;
        if (bus.m_done) begin
          complete = 1'b1;
          cpl_err  = err_q | bus.m_ackErr;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (complete) begin
      state_d              = StResp;
      rsp_valid_d[owner_q] = 1'b1;
      rsp_data_d           = bus.m_dout;
      rsp_err_d            = cpl_err;
    end else if (timeout) begin
      // Abort: drop the command, keep the previous read data.
      state_d              = StResp;
      m_dv_d               = 1'b0;
      rsp_valid_d[owner_q] = 1'b1;
      rsp_err_d            = 1'b1;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      m_rw_q      <= 1'b0;
      m_dv_q      <= 1'b0;
      m_addr_q    <= '0;
      m_din_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      m_rw_q      <= m_rw_d;
      m_dv_q      <= m_dv_d;
      m_addr_q    <= m_addr_d;
      m_din_q     <= m_din_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Define I2C_ARB_TIMEOUT_EN to also exercise the timeout abort path.
module tb_i2c_arbiter;
  import i2c_arb_pkg::*;

  localparam int unsigned TimeoutCycles = 50;

  logic clk = 1'b0;
  logic rst;

  i2c_arbiter_if bus ();

  i2c_arbiter #(
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state: who was granted last, last response data, requester fields.
  int          last_gnt  = 1;
  logic [7:0]  last_data = 8'h00;
  logic        exp_rw   [2];
  logic [6:0]  exp_addr [2];
  logic [7:0]  exp_din  [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int model_pick(input logic [1:0] v);
    if (v == 2'b11) return (last_gnt == 0) ? 1 : 0;
    return v[1] ? 1 : 0;
  endfunction

  function automatic logic ack_val(input int mode, input int i);
    if (mode == 1) return (i == 0);
    if (mode == 2) return ($urandom_range(0, 3) == 0);
    return 1'b0;
  endfunction

  task automatic set_req(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_rw[i]    = rw;
    bus.req_addr[i]  = a;
    bus.req_din[i]   = d;
    exp_rw[i]        = rw;
    exp_addr[i]      = a;
    exp_din[i]       = d;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    check_val({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check_val({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
    check_val({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
    check_val({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 0);
    check_val({tag, "_m_dv"}, 32'(bus.m_dataValid), 0);
    check_val({tag, "_m_rw"}, 32'(bus.m_rw), 0);
    check_val({tag, "_m_addr"}, 32'(bus.m_addr), 0);
    check_val({tag, "_m_din"}, 32'(bus.m_din), 0);
  endtask

  // Waits for a grant; returns the model's owner, or -1 if no grant came.
  task automatic await_grant(output int own);
    int n;
    n = 0;
    tick();
    while (bus.req_ready == 2'b00 && n < 10) begin
      tick();
      n++;
    end
    check_val("grant_seen", 32'(bus.req_ready != 2'b00), 1);
    own = -1;
    if (bus.req_ready != 2'b00) begin
      own      = model_pick(bus.req_valid);
      last_gnt = own;
      check_val("grant_latency", n, 0);
      check_val("req_ready", 32'(bus.req_ready), 32'(1) << own);
      check_val("issue_dv", 32'(bus.m_dataValid), 1);
      check_val("m_rw", 32'(bus.m_rw), 32'(exp_rw[own]));
      check_val("m_addr", 32'(bus.m_addr), 32'(exp_addr[own]));
      check_val("m_din", 32'(bus.m_din), 32'(exp_din[own]));
      bus.req_valid[own] = 1'b0;
    end
  endtask

  // One full command: grant, master handshake, response check.
  task automatic run_txn(input int bd, input bit same, input int dd, input int ack_mode,
                         input logic [7:0] dout, input bit glitch, input bit abort_rst);
    int         own;
    logic       err_m;
    logic [6:0] e_addr;
    await_grant(own);
    if (own < 0) return;
    e_addr = exp_addr[own];
    tick();
    repeat (bd) begin
      check_val("hold_dv", 32'(bus.m_dataValid), 1);
      tick();
    end
    err_m      = 1'b0;
    bus.m_busy = 1'b1;
    if (same) begin
      bus.m_done = 1'b1;
      bus.m_dout = dout;
      tick();
      bus.m_busy = 1'b0;
      bus.m_done = 1'b0;
    end else begin
      tick();
      check_val("dv_drop", 32'(bus.m_dataValid), 0);
      if (abort_rst) begin
        set_req(0, 1'b0, 7'h22, 8'h11);
        set_req(1, 1'b1, 7'h33, 8'h44);
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        bus.m_busy = 1'b0;
        last_gnt   = 1;
        last_data  = 8'h00;
        check_all_zero("rst_mid");
        return;
      end
      for (int i = 0; i < dd; i++) begin
        if (glitch) bus.req_valid[0] = (i == 0);
        bus.m_ackErr = ack_val(ack_mode, i);
        err_m        = err_m | bus.m_ackErr;
        tick();
      end
      if (glitch) bus.req_valid[0] = 1'b0;
      bus.m_ackErr = ack_val(ack_mode, dd);
      err_m        = err_m | bus.m_ackErr;
      bus.m_busy   = 1'b0;
      bus.m_done   = 1'b1;
      bus.m_dout   = dout;
      tick();
      bus.m_done   = 1'b0;
      bus.m_ackErr = 1'b0;
    end
    check_val("rsp_valid", 32'(bus.rsp_valid), 32'(1) << own);
    check_val("rsp_data", 32'(bus.rsp_data), 32'(dout));
    check_val("rsp_err", 32'(bus.rsp_err), 32'(err_m));
    check_val("rsp_timeout", 32'(bus.rsp_timeout), 0);
    last_data = dout;
    tick();
    check_val("rsp_pulse", 32'(bus.rsp_valid), 0);
    check_val("m_addr_hold", 32'(bus.m_addr), 32'(e_addr));
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  // Master never raises busy; the arbiter must abort after the wait budget.
  task automatic run_timeout();
    int own;
    int n;
    await_grant(own);
    if (own < 0) return;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 10) check_val("to_hold_dv", 32'(bus.m_dataValid), 1);
    end while (bus.rsp_valid == 2'b00 && n < 200);
    check_val("to_latency", n, TimeoutCycles + 1);
    check_val("to_rsp_valid", 32'(bus.rsp_valid), 32'(1) << own);
    check_val("to_rsp_err", 32'(bus.rsp_err), 1);
    check_val("to_rsp_timeout", 32'(bus.rsp_timeout), 1);
    check_val("to_rsp_data", 32'(bus.rsp_data), 32'(last_data));
    check_val("to_m_dv", 32'(bus.m_dataValid), 0);
    tick();
    check_val("to_rsp_pulse", 32'(bus.rsp_valid), 0);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_din   = '0;
    bus.m_dout    = '0;
    bus.m_busy    = 1'b0;
    bus.m_ackErr  = 1'b0;
    bus.m_done    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_rw[i]   = 1'b0;
      exp_addr[i] = '0;
      exp_din[i]  = '0;
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Contention from reset: 0, then 1, then a fresh double request goes to 0 again.
    set_req(0, 1'b0, 7'h10, 8'h01);
    set_req(1, 1'b0, 7'h11, 8'h02);
    run_txn(0, 1'b0, 1, 0, 8'h00, 1'b0, 1'b0);
    run_txn(1, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);
    set_req(0, 1'b1, 7'h12, 8'h03);
    set_req(1, 1'b1, 7'h13, 8'h04);
    run_txn(0, 1'b1, 0, 0, 8'h5A, 1'b0, 1'b0);
    run_txn(2, 1'b0, 2, 0, 8'h6B, 1'b0, 1'b0);

    // Single write.
    set_req(0, 1'b0, 7'h50, 8'hA5);
    run_txn(1, 1'b0, 2, 0, 8'h00, 1'b0, 1'b0);

    // Read with one NACK pulse.
    set_req(1, 1'b1, 7'h51, 8'h00);
    run_txn(0, 1'b0, 3, 1, 8'h3C, 1'b0, 1'b0);

    // Glitch on requester 0 while the master is working: must never be granted.
    set_req(1, 1'b0, 7'h52, 8'h77);
    run_txn(0, 1'b0, 3, 0, 8'h99, 1'b1, 1'b0);
    repeat (3) begin
      tick();
      check_val("glitch_no_ready", 32'(bus.req_ready), 0);
    end

    // Reset in WAIT_DONE after requester 0 was served; pending pair then goes to 0.
    set_req(0, 1'b0, 7'h60, 8'h61);
    run_txn(0, 1'b0, 2, 0, 8'h00, 1'b0, 1'b1);
    run_txn(0, 1'b0, 1, 0, 8'hC1, 1'b0, 1'b0);
    run_txn(0, 1'b0, 1, 0, 8'hC2, 1'b0, 1'b0);

`ifdef I2C_ARB_TIMEOUT_EN
    set_req(1, 1'b1, 7'h70, 8'h00);
    run_timeout();
`endif

    // Randomized traffic; unserved requesters stay pending with unchanged fields.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
                  8'($urandom_range(0, 255)));
      end
      if (bus.req_valid == 2'b00)
        set_req($urandom_range(0, 1), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
                8'($urandom_range(0, 255)));
      run_txn($urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom_range(0, 4), 2,
              8'($urandom_range(0, 255)), 1'b0, 1'b0);
    end
    for (int k = 0; k < 2 && bus.req_valid != 2'b00; k++) begin
      run_txn(0, 1'b0, 1, 2, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
